// File: rtl/credit_lookup_fifo.sv
// Credit-based lookup stage: address stream in, fixed-latency RAM reads out, read words returned
// through an output FIFO whose depth sets the number of credits, so no returning word is dropped.
module credit_lookup_fifo #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] in_tdata,
    input  logic              in_tlast,
    input  logic              in_tvalid,
    output logic              in_tready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_read,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic [DATA_W-1:0] out_tdata,
    output logic              out_tlast,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic [CNT_W-1:0]  credit_cnt,
    output logic              protocol_err
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic                  init_q;
    logic [CNT_W-1:0]      credit_q, credit_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [PTR_W-1:0]      dwr_q, rd_q;
    logic [IDX_W-1:0]      twr_q;
    logic [DATA_W-1:0]     data_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] tag_q;
    logic                  err_q;

    logic issue, pop, ret_ok, fifo_empty, fifo_full;

    // Ready stays low for the first edge after reset release so it never follows aresetn directly.
    assign in_tready  = init_q & (credit_q != '0);
    assign issue      = in_tvalid & in_tready;
    assign rd_read    = issue;
    assign rd_addr    = in_tdata;

    assign fifo_empty = (dwr_q == rd_q);
    assign fifo_full  = (dwr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]) && (dwr_q[IDX_W] != rd_q[IDX_W]);
    assign out_tvalid = !fifo_empty;
    assign pop        = out_tvalid & out_tready;
    assign ret_ok     = rd_valid & (outst_q != '0) & !fifo_full;

    assign out_tdata    = out_tvalid ? data_mem_q[rd_q[IDX_W-1:0]] : '0;
    assign out_tlast    = out_tvalid & tag_q[rd_q[IDX_W-1:0]];
    assign credit_cnt   = credit_q;
    assign protocol_err = err_q;

    always_comb begin
        credit_d = credit_q;
        if (issue && !pop) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (pop && !issue) begin
            credit_d = credit_q + CNT_W'(1);
        end

        outst_d = outst_q;
        if (issue && !ret_ok) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (ret_ok && !issue) begin
            outst_d = outst_q - CNT_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            init_q   <= 1'b0;
            credit_q <= CNT_W'(FIFO_DEPTH);
            outst_q  <= '0;
            dwr_q    <= '0;
            rd_q     <= '0;
            twr_q    <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            init_q   <= 1'b1;
            credit_q <= credit_d;
            outst_q  <= outst_d;
            if (issue) begin
                tag_q[twr_q] <= in_tlast;
                twr_q        <= twr_q + IDX_W'(1);
            end
            if (ret_ok) begin
                dwr_q <= dwr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            // A return with nothing outstanding is a RAM-side fault; flag it until reset.
            if (rd_valid && (outst_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge aclk) begin
        if (ret_ok) begin
            data_mem_q[dwr_q[IDX_W-1:0]] <= rd_data;
        end
    end

endmodule

// File: tb/tb_credit_lookup_fifo.sv
// Self-checking bench for credit_lookup_fifo: 1-cycle RAM model (mem[a]=16'h0A00+a), directed
// scenarios plus randomized traffic against a queue-based scoreboard.
module tb_credit_lookup_fifo;

    localparam int DEPTH = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  in_tdata = '0;
    logic        in_tlast = 1'b0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [7:0]  rd_addr;
    logic        rd_read;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [15:0] out_tdata;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready = 1'b0;
    logic [2:0]  credit_cnt;
    logic        protocol_err;

    logic        ram_valid;
    logic [15:0] ram_data;
    logic        spur_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    int mon_pops = 0;
    logic [16:0] exp_q [$];

    always #5 aclk = ~aclk;

    credit_lookup_fifo dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .in_tdata    (in_tdata),
        .in_tlast    (in_tlast),
        .in_tvalid   (in_tvalid),
        .in_tready   (in_tready),
        .rd_addr     (rd_addr),
        .rd_read     (rd_read),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .out_tdata   (out_tdata),
        .out_tlast   (out_tlast),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .credit_cnt  (credit_cnt),
        .protocol_err(protocol_err)
    );

    // RAM model with one cycle of latency; its pipeline is flushed by reset like the DUT.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ram_valid <= 1'b0;
            ram_data  <= '0;
        end else begin
            ram_valid <= rd_read;
            ram_data  <= 16'h0A00 + {8'h00, rd_addr};
        end
    end
    assign rd_valid = ram_valid | spur_valid;
    assign rd_data  = spur_valid ? 16'hDEAD : ram_data;

    // Scoreboard: every accepted request owes exactly one output, in order.
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
        end else begin
            checks++;
            if (credit_cnt !== 3'(DEPTH - exp_q.size())) begin
                errors++;
                $display("FAIL credit_track got %0d expected %0d", credit_cnt, DEPTH - exp_q.size());
            end
            if (exp_q.size() == DEPTH) begin
                checks++;
                if (in_tready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready got %b expected 0", in_tready);
                end
            end
            if (out_tvalid && out_tready) begin
                checks++;
                mon_pops++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_empty got %h expected no output", out_tdata);
                end else if ({out_tlast, out_tdata} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL sb_data got %h expected %h", {out_tlast, out_tdata}, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (in_tvalid && in_tready) begin
                exp_q.push_back({in_tlast, 16'h0A00 + {8'h00, in_tdata}});
            end
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn    = 1'b0;
        in_tvalid  = 1'b0;
        out_tready = 1'b0;
        spur_valid = 1'b0;
        repeat (2) cyc();
        aresetn = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) cyc();
        checks++;
        if (in_tready !== 1'b0 || out_tvalid !== 1'b0 || credit_cnt !== 3'd4 ||
            out_tdata !== 16'h0 || out_tlast !== 1'b0 || rd_read !== 1'b0 || protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b ov=%b cr=%0d od=%h ol=%b rr=%b pe=%b expected 0,0,4,0,0,0,0",
                     in_tready, out_tvalid, credit_cnt, out_tdata, out_tlast, rd_read, protocol_err);
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if (in_tready !== 1'b0) begin
            errors++;
            $display("FAIL release_ready_early got %b expected 0", in_tready);
        end
        cyc();
        checks++;
        if (in_tready !== 1'b1 || credit_cnt !== 3'd4) begin
            errors++;
            $display("FAIL release_ready got rdy=%b cr=%0d expected 1,4", in_tready, credit_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int t_out [3];
        logic [15:0] got [3];
        out_tready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_tvalid = (c < 3);
            in_tdata  = 8'(c);
            in_tlast  = 1'b0;
            @(negedge aclk);
            if (c < 3) begin
                checks++;
                if (in_tready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready cycle %0d got %b expected 1", c, in_tready);
                end
            end
            if (out_tvalid && n < 3) begin
                got[n]   = out_tdata;
                t_out[n] = c;
                n++;
            end
            cyc();
        end
        in_tvalid = 1'b0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL b2b_count got %0d expected 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== 16'h0A00 + 16'(i) || t_out[i] != 2 + i) begin
                    errors++;
                    $display("FAIL b2b_word%0d got %h@%0d expected %h@%0d",
                             i, got[i], t_out[i], 16'h0A00 + 16'(i), 2 + i);
                end
            end
        end
        checks++;
        if (credit_cnt !== 3'd4) begin
            errors++;
            $display("FAIL b2b_credit got %0d expected 4", credit_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  nxt = 8'h10;
        int          acc = 0;
        int          n = 0;
        logic [15:0] got [16];
        for (int c = 0; c < 200 && n < 16; c++) begin
            out_tready = (c >= 20);
            in_tvalid  = (nxt <= 8'h1F);
            in_tdata   = nxt;
            in_tlast   = 1'b0;
            @(negedge aclk);
            if (c >= 6 && c < 20) begin
                checks++;
                if (out_tvalid !== 1'b1 || out_tdata !== 16'h0A10) begin
                    errors++;
                    $display("FAIL bp_hold cycle %0d got %b/%h expected 1/0a10", c, out_tvalid, out_tdata);
                end
            end
            if (c == 19) begin
                checks++;
                if (acc != 4 || in_tready !== 1'b0 || credit_cnt !== 3'd0) begin
                    errors++;
                    $display("FAIL bp_full got acc=%0d rdy=%b cr=%0d expected 4,0,0", acc, in_tready, credit_cnt);
                end
            end
            if (in_tvalid && in_tready) begin
                nxt++;
                acc++;
            end
            if (out_tvalid && out_tready) begin
                got[n] = out_tdata;
                n++;
            end
            cyc();
        end
        in_tvalid = 1'b0;
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL bp_count got %0d expected 16", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== 16'h0A10 + 16'(i)) begin
                errors++;
                $display("FAIL bp_order idx %0d got %h expected %h", i, got[i], 16'h0A10 + 16'(i));
            end
        end
    endtask

    task automatic test_tlast();
        logic [7:0] nxt = 8'h20;
        int         n = 0;
        out_tready = 1'b1;
        for (int c = 0; c < 60 && n < 8; c++) begin
            in_tvalid = (nxt <= 8'h27);
            in_tdata  = nxt;
            in_tlast  = (nxt == 8'h23) || (nxt == 8'h27);
            @(negedge aclk);
            if (in_tvalid && in_tready) nxt++;
            if (out_tvalid && out_tready) begin
                checks++;
                if (out_tdata !== 16'h0A20 + 16'(n) ||
                    out_tlast !== ((n == 3) || (n == 7))) begin
                    errors++;
                    $display("FAIL tlast idx %0d got %h/%b expected %h/%b", n, out_tdata, out_tlast,
                             16'h0A20 + 16'(n), (n == 3) || (n == 7));
                end
                n++;
            end
            cyc();
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL tlast_count got %0d expected 8", n);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        out_tready = 1'b1;
        spur_valid = 1'b1;
        cyc();
        spur_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            checks++;
            if (protocol_err !== 1'b1 || out_tvalid !== 1'b0 || credit_cnt !== 3'd4) begin
                errors++;
                $display("FAIL spurious got pe=%b ov=%b cr=%0d expected 1,0,4", protocol_err, out_tvalid, credit_cnt);
            end
            cyc();
        end
        do_reset();
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL spurious_clear got %b expected 0", protocol_err);
        end
    endtask

    task automatic run_random(input int n, input bit drain);
        int start = mon_pops;
        int issued = 0;
        int gap = 0;
        int run = 0;
        bit hi = 1'b0;
        bit acc;
        for (int c = 0; c < 20000; c++) begin
            if (drain && (mon_pops - start) >= n) break;
            if (!drain && issued >= n) break;
            while (run == 0) begin
                hi  = !hi;
                run = hi ? int'($urandom_range(0, 24)) : int'($urandom_range(1, 32));
            end
            out_tready = hi;
            run--;
            if (!in_tvalid) begin
                if (gap > 0) begin
                    gap--;
                end else if (issued < n) begin
                    in_tvalid = 1'b1;
                    in_tdata  = 8'($urandom);
                    in_tlast  = 1'($urandom);
                end
            end
            @(negedge aclk);
            checks++;
            if (credit_cnt > 3'd4) begin
                errors++;
                $display("FAIL credit_range got %0d expected <=4", credit_cnt);
            end
            acc = in_tvalid && in_tready;
            if (acc) issued++;
            cyc();
            if (acc) begin
                in_tvalid = 1'b0;
                gap       = $urandom_range(0, 3);
            end
        end
        in_tvalid = 1'b0;
        if (drain) begin
            checks++;
            if (mon_pops - start != n || protocol_err !== 1'b0) begin
                errors++;
                $display("FAIL random_drain got %0d outputs pe=%b expected %0d outputs pe=0",
                         mon_pops - start, protocol_err, n);
            end
        end
    endtask

    task automatic test_mid_reset();
        run_random(120, 1'b0);
        do_reset();
        checks++;
        if (credit_cnt !== 3'd4 || out_tvalid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset got cr=%0d ov=%b expected 4,0", credit_cnt, out_tvalid);
        end
        run_random(500, 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_tlast();
        test_spurious();
        test_mid_reset();
        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
